// File: rtl/register_bank.sv
// DEPTH x WIDTH register bank: one synchronous write port, two combinational read
// ports, optional write-to-read bypass and hard-wired zero entry, sequential clear engine.
module register_bank #(
    parameter int WIDTH    = 16,
    parameter int DEPTH    = 8,
    parameter int ADDR_W   = $clog2(DEPTH),
    parameter bit BYPASS   = 1'b0,
    parameter bit ZERO_REG = 1'b0
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              write_signal,
    input  logic [ADDR_W-1:0] write_addr,
    input  logic [WIDTH-1:0]  input_value,
    input  logic [ADDR_W-1:0] read_addr_a,
    input  logic [ADDR_W-1:0] read_addr_b,
    output logic [WIDTH-1:0]  output_value_a,
    output logic [WIDTH-1:0]  output_value_b,
    input  logic              clear_req,
    output logic              busy,
    output logic              write_rejected
);

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t                        state_q, state_d;
    logic [ADDR_W-1:0]             ptr_q, ptr_d;
    logic [DEPTH-1:0][WIDTH-1:0]   mem_q, mem_d;
    logic                          wr_en;
    logic [1:0][ADDR_W-1:0]        raddr;
    logic [1:0][WIDTH-1:0]         rdata;

    assign busy           = (state_q == CLEAR);
    assign write_rejected = write_signal && busy;
    // Writes to a hard-wired zero entry are silently discarded, not rejected.
    assign wr_en = write_signal && !busy && !(ZERO_REG && (write_addr == '0));

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        case (state_q)
            IDLE: begin
                if (clear_req) begin
                    state_d = CLEAR;
                    ptr_d   = '0;
                end
            end
            CLEAR: begin
                if (ptr_q == ADDR_W'(DEPTH - 1)) begin
                    state_d = IDLE;
                    ptr_d   = '0;
                end else begin
                    ptr_d = ptr_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                ptr_d   = '0;
            end
        endcase
    end

    always_comb begin
        mem_d = mem_q;
        if (busy) begin
            mem_d[ptr_q] = '0;
        end else if (wr_en) begin
            mem_d[write_addr] = input_value;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            mem_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            mem_q   <= mem_d;
        end
    end

    assign raddr[0] = read_addr_a;
    assign raddr[1] = read_addr_b;

    // Zero entry overrides bypass; bypass is off while the clear engine runs.
    for (genvar p = 0; p < 2; p++) begin : g_rd
        always_comb begin
            rdata[p] = mem_q[raddr[p]];
            if (BYPASS && write_signal && !busy && (write_addr == raddr[p])) begin
                rdata[p] = input_value;
            end
            if (ZERO_REG && (raddr[p] == '0)) begin
                rdata[p] = '0;
            end
        end
    end

    assign output_value_a = rdata[0];
    assign output_value_b = rdata[1];

endmodule

// File: doc/register_bank.md
# register_bank

Parametrised multi-entry register bank for the double accumulator processor, generalising the single 16-bit register into DEPTH words of WIDTH bits. It has one synchronous write port, two independent combinational read ports (A and B, feeding both accumulator datapaths), optional write-to-read bypass, and a multi-cycle sequential clear engine with a busy indication. It sits between the control unit (write enable and addresses) and the ALU operand muxes.

## Interface
- WIDTH, 16, data word width in bits (≥1)
- DEPTH, 8, number of entries; power of two, ≥2
- ADDR_W, $clog2(DEPTH), address width; derived, do not override
- BYPASS, 0, 1 = a read of the address being written in this cycle returns input_value combinationally
- ZERO_REG, 0, 1 = entry 0 always reads 0 and writes to it are discarded

- CLK  input  1  clock; all state updates on the rising edge
- RST  input  1  synchronous, active-high reset
- write_signal  input  1  write enable
- write_addr  input  ADDR_W  write address
- input_value  input  WIDTH  write data
- read_addr_a  input  ADDR_W  read port A address
- read_addr_b  input  ADDR_W  read port B address
- output_value_a  output  WIDTH  port A read data, combinational from read_addr_a
- output_value_b  output  WIDTH  port B read data, combinational from read_addr_b
- clear_req  input  1  starts a sequential clear of all entries
- busy  output  1  high while the clear engine is running
- write_rejected  output  1  combinational; high when write_signal=1 while busy=1

## Operation
- Reset: at a rising edge with RST=1, every entry becomes 0, the state machine goes to IDLE, the clear pointer goes to 0, and busy goes to 0. RST has priority over clear_req and write_signal.
- Write: in IDLE, with write_signal=1 at the edge, entry[write_addr] takes input_value. With ZERO_REG=1 and write_addr=0, the write is discarded (it is not rejected).
- Read: output_value_x = entry[read_addr_x]. The same address may be read on both ports at the same time.
  - BYPASS=1, write_signal=1, busy=0, write_addr==read_addr_x: output_value_x = input_value.
  - ZERO_REG=1, read_addr_x==0: output is 0. This overrides bypass.
- State machine:
  - IDLE: on clear_req=1 at the edge, go to CLEAR with ptr=0. A write present in that same cycle is still performed.
  - CLEAR: at each edge, entry[ptr] becomes 0 and ptr increments. At the edge where ptr==DEPTH-1, go to IDLE and set ptr to 0.
- busy = (state==CLEAR).
- While busy:
  - writes are dropped and write_rejected=1;
  - clear_req is ignored;
  - reads return current contents, which can be a mix of cleared and uncleared entries; bypass is disabled.
- RST during CLEAR aborts the clear. Every entry is 0 after that edge in any case.

## Timing
- Write latency: data written at edge N is visible on the read ports after edge N (BYPASS=0), or during the cycle before N (BYPASS=1).
- Read latency: 0 cycles (combinational).
- Clear: with clear_req sampled at edge E, busy is high from after E until after edge E+DEPTH, i.e. for exactly DEPTH cycles.
  - Entry k is zeroed at edge E+1+k.
  - A write can first be accepted at edge E+DEPTH+1.
- Back-to-back writes: one per cycle, with no stall in IDLE.
- Simultaneous write and read of the same address with BYPASS=0: the read returns the old value in that cycle.

## Test plan
- Reset: assert RST for 1 edge after random writes → all entries read 0x0000 on both ports; busy=0.
- Write/read, WIDTH=16, DEPTH=8: write 0xC5A0 to addr 3 and 0xFFFF to addr 7 → A(3)=0xC5A0 and B(7)=0xFFFF after the edges; write 0x1234 to addr 3 with A reading 3 → with BYPASS=0, A=0xC5A0 in that cycle and 0x1234 after; with BYPASS=1, A=0x1234 in the same cycle.
- ZERO_REG=1: write 0xBEEF to addr 0 → both ports read 0x0000 at addr 0; write_rejected=0.
- Clear: fill entries 0..7 with 0x1111·(k+1), then pulse clear_req → busy high for exactly 8 cycles, entry 2 is still 0x3333 one cycle into the clear and 0 after edge E+3, all entries are 0 at the end; a write of 0xAAAA to addr 5 during busy gives write_rejected=1 and entry 5 ends at 0.
- Reset mid-clear: assert RST at cycle 4 of a clear → busy=0 next cycle, all entries 0; a subsequent write of 0x5A5A to addr 6 is accepted immediately.
- Clear and write in the same IDLE cycle: clear_req=1 with a write of 0x7777 to addr 1 → entry 1 reads 0x7777 after edge E and 0 after edge E+2.
